// File: rtl/ysyx_22040931_div_server_if.sv
// ysyx_22040931_div_server_if: request/response handshake bundle between the EX-stage ALU and the divider
interface ysyx_22040931_div_server_if #(parameter int DATA_W = 64);
  logic div_valid, div_ready, w, div_signed, out_valid, out_ready;
  logic [DATA_W-1:0] dividend, divisor, quotient, remainder;
  modport master (
    output div_valid, w, div_signed, dividend, divisor, out_ready,
    input  div_ready, out_valid, quotient, remainder
  );
  modport slave (
    input  div_valid, w, div_signed, dividend, divisor, out_ready,
    output div_ready, out_valid, quotient, remainder
  );
endinterface

// File: rtl/ysyx_22040931_div_server.sv
// ysyx_22040931_div_server: radix-2 restoring RV64M divide/remainder unit with valid/ready request and response
module ysyx_22040931_div_server #(
  parameter int DATA_W = 64,
  parameter int CNT_W  = 7
) (
  input logic clock,
  input logic reset,
  input logic flush,
  ysyx_22040931_div_server_if.slave bus
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state, state_n;
  logic [DATA_W-1:0] q, r, d, q_res, r_res;
  logic [DATA_W-1:0] a_ext, b_ext, a_mag, b_mag, mn, q_sp, r_sp, q_it, r_it, q_fix, r_fix;
  logic [DATA_W:0] rs, sub;
  logic [CNT_W-1:0] cnt;
  logic a_neg, b_neg, q_neg, r_neg, w_r, accept, dz, ovf;

  function automatic logic [DATA_W-1:0] sx(input logic [DATA_W-1:0] x);
    return {{(DATA_W-32){x[31]}}, x[31:0]};
  endfunction

  always_comb begin
    a_ext = bus.w ? (bus.div_signed ? sx(bus.dividend) : {{(DATA_W-32){1'b0}}, bus.dividend[31:0]}) : bus.dividend;
    b_ext = bus.w ? (bus.div_signed ? sx(bus.divisor) : {{(DATA_W-32){1'b0}}, bus.divisor[31:0]}) : bus.divisor;
    a_neg = bus.div_signed & a_ext[DATA_W-1];
    b_neg = bus.div_signed & b_ext[DATA_W-1];
    a_mag = a_neg ? -a_ext : a_ext;
    b_mag = b_neg ? -b_ext : b_ext;
    mn = bus.w ? {{(DATA_W-31){1'b1}}, {31{1'b0}}} : {1'b1, {(DATA_W-1){1'b0}}};
    dz = b_ext == '0;
    ovf = bus.div_signed & (a_ext == mn) & (&b_ext);
    q_sp = dz ? '1 : a_ext;
    r_sp = dz ? a_ext : '0;
    accept = bus.div_valid & (state == IDLE);
    rs = {r, q[DATA_W-1]};
    sub = rs - {1'b0, d};
    q_it = {q[DATA_W-2:0], ~sub[DATA_W]};
    r_it = sub[DATA_W] ? rs[DATA_W-1:0] : sub[DATA_W-1:0];
    q_fix = q_neg ? -q_it : q_it;
    r_fix = r_neg ? -r_it : r_it;
  end

  always_ff @(posedge clock or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_n;

  always_comb
    state_n = flush ? IDLE :
              state == IDLE ? (accept ? ((dz | ovf) ? DONE : CALC) : IDLE) :
              state == CALC ? (cnt == CNT_W'(1) ? DONE : CALC) :
              (bus.out_ready ? IDLE : DONE);

  always_comb begin
    bus.div_ready = state == IDLE;
    bus.out_valid = state == DONE;
    bus.quotient = q_res;
    bus.remainder = r_res;
  end

  // W operands sit in the top half so the shift starts at their bit 31
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      q <= '0;
      r <= '0;
      d <= '0;
      cnt <= '0;
      q_neg <= 1'b0;
      r_neg <= 1'b0;
      w_r <= 1'b0;
      q_res <= '0;
      r_res <= '0;
    end else if (!flush) begin
      if (accept) begin
        q <= bus.w ? {a_mag[31:0], {(DATA_W-32){1'b0}}} : a_mag;
        r <= '0;
        d <= b_mag;
        cnt <= bus.w ? CNT_W'(32) : CNT_W'(DATA_W);
        q_neg <= a_neg ^ b_neg;
        r_neg <= a_neg;
        w_r <= bus.w;
        if (dz | ovf) begin
          q_res <= bus.w ? sx(q_sp) : q_sp;
          r_res <= bus.w ? sx(r_sp) : r_sp;
        end
      end else if (state == CALC) begin
        q <= q_it;
        r <= r_it;
        cnt <= cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          q_res <= w_r ? sx(q_fix) : q_fix;
          r_res <= w_r ? sx(r_fix) : r_fix;
        end
      end
    end
endmodule
